dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of 32-bit RAM words; a power of two, at least 4.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and the access; range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: core presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: write data.
REQ-010 The block SHALL have port req_be, input, 4 bits: byte enables; bit i gates byte lane i for writes.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: core accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: read data.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: access fault.
REQ-015 The block SHALL have port led_out, output, 8 bits: MMIO LED register value.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 exactly when state is IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 in IDLE; req_we, req_addr, req_wdata and req_be SHALL be registered at that edge and ignored afterwards.
REQ-018 On acceptance the FSM SHALL enter WAIT with the wait counter loaded to LATENCY; with LATENCY=0 it SHALL enter RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle; the edge where it reaches 0 SHALL perform the access and move the FSM to RESP.
REQ-020 For a request accepted at edge T, rsp_valid SHALL be 1 from edge T+1+LATENCY.
REQ-021 rsp_valid, rsp_rdata and rsp_err SHALL hold stable in RESP until an edge with rsp_ready=1, after which the FSM SHALL return to IDLE.
REQ-022 Back-to-back requests SHALL be supported with one IDLE cycle between a response handshake and the next acceptance.
REQ-023 Address map: RAM at 0x0000_0000 to DEPTH*4-1, indexed by addr[log2(DEPTH)+1:2]; LED register at 0x1000_0000 (bits 7:0 R/W, upper bits read 0); cycle counter at 0x1000_0004 (read-only).
REQ-024 A RAM write SHALL update only byte lanes with req_be[i]=1; req_be=0 SHALL leave memory unchanged and return rsp_err=0.
REQ-025 An LED write SHALL update led_out from wdata[7:0] when be[0]=1; led_out SHALL change at the access edge.
REQ-026 Reads SHALL ignore req_be and return the full 32-bit word.
REQ-027 The access SHALL raise rsp_err=1, force rsp_rdata=0 and perform no write when addr[1:0]≠0, when the address is unmapped, or on a write to the cycle counter.
REQ-028 The cycle counter SHALL be a free-running 32-bit counter, incrementing every cycle and wrapping from 0xFFFF_FFFF to 0.
REQ-029 A counter read SHALL return its value at the access edge.
REQ-030 rsp_rdata SHALL be 0 whenever rsp_valid=0.
REQ-031 rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-032 While reset=1 the FSM SHALL be in IDLE, giving req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-033 While reset=1, led_out, the cycle counter and the wait counter SHALL be 0.
REQ-034 RAM contents SHALL be unaffected by reset.
REQ-035 Reset asserted in WAIT or RESP SHALL abort the transaction immediately; a write not yet performed SHALL never occur.

Verification
REQ-036 With LATENCY=2, write 0xDEADBEEF to 0x8 with be=1111 accepted at edge T, then read 0x8 -> rsp_valid at T+3 for both; read returns 0xDEADBEEF with rsp_err=0.
REQ-037 After the scenario of REQ-036, write 0x00001100 to 0x8 with be=0010, then read 0x8 -> returns 0xDEAD11EF.
REQ-038 Read 0x6 (misaligned), read 0x2000_0000 and write 0x1000_0004 -> each returns rsp_err=1 and rsp_rdata=0; RAM and counter are unchanged.
REQ-039 Write 0x1A5 to 0x1000_0000 with be=0001 -> led_out=0xA5; a subsequent read of 0x1000_0000 returns 0x000000A5.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0; rsp_ready=1 -> IDLE on the next edge.
REQ-041 Assert reset in WAIT on a write to 0x4 holding 0x11111111 -> after reset, read 0x4 returns 0x11111111 and led_out=0.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Single-outstanding data-memory responder for a core's load/store port.
//   A request is captured when the FSM is IDLE, waits LATENCY cycles, performs
//   one access against a small word RAM or one of two MMIO registers (LED,
//   free-running cycle counter) and then holds the response until the core
//   takes it.
//
// Handshake semantics: a transfer happens on a rising clk edge where both
//   valid and ready are 1. req_* fields are only sampled on the request
//   transfer edge. rsp_valid/rsp_rdata/rsp_err stay constant from the first
//   cycle rsp_valid is 1 until the response transfer edge.
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready   request handshake (req_ready = 1 exactly in IDLE)
//   req_we                  1 = write, 0 = read
//   req_addr [31:0]         byte address
//   req_wdata[31:0]         write data
//   req_be   [3:0]          byte-lane write enables (ignored for reads)
//   rsp_valid / rsp_ready   response handshake
//   rsp_rdata[31:0]         read data (0 for writes, faults, or when !rsp_valid)
//   rsp_err                 access fault (0 when !rsp_valid)
//   led_out  [7:0]          MMIO LED register
//
// Address map:
//   0x0000_0000 .. DEPTH*4-1   RAM, word-indexed by addr[log2(DEPTH)+1:2]
//   0x1000_0000                LED register (bits 7:0 R/W, upper bits read 0)
//   0x1000_0004                cycle counter (read-only)
//   Misaligned, unmapped, or counter-write accesses fault: rsp_err=1, no write.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  led_out
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  LAT      = 4'(LATENCY);
    localparam logic [31:0] LED_ADDR = 32'h1000_0000;
    localparam logic [31:0] CYC_ADDR = 32'h1000_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        fire;          // the access happens on this edge
    logic        accept;

    logic [3:0]  wcnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] cyc_q;
    logic [7:0]  led_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    // Access operands: with no wait stage the access happens on the acceptance
    // edge itself, so it must use the live request rather than the captured copy.
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;

    generate
        if (LATENCY == 0) begin : g_direct
            assign a_we    = req_we;
            assign a_addr  = req_addr;
            assign a_wdata = req_wdata;
            assign a_be    = req_be;
        end else begin : g_waited
            assign a_we    = we_q;
            assign a_addr  = addr_q;
            assign a_wdata = wdata_q;
            assign a_be    = be_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign accept = (state_q == IDLE) && req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Counter sits at 0 for one edge before the access, giving the
                // response LATENCY+1 edges after acceptance.
                if (wcnt_q == 4'd0) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode and access result
    // ------------------------------------------------------------------
    logic          is_ram, is_led, is_cyc, acc_err;
    logic [AW-1:0] ram_idx;
    logic [31:0]   acc_rdata;
    logic          ram_we, led_we;

    always_comb begin
        is_ram    = (a_addr[31:AW+2] == '0);
        is_led    = (a_addr == LED_ADDR);
        is_cyc    = (a_addr == CYC_ADDR);
        ram_idx   = a_addr[AW+1:2];
        acc_err   = (a_addr[1:0] != 2'b00)
                  | ~(is_ram | is_led | is_cyc)
                  | (a_we & is_cyc);
        acc_rdata = 32'h0;
        if (!acc_err && !a_we) begin
            if (is_ram) begin
                acc_rdata = mem[ram_idx];
            end else if (is_led) begin
                acc_rdata = {24'h0, led_q};
            end else begin
                acc_rdata = cyc_q;
            end
        end
    end

    // The RAM has no reset, so its write enable carries reset explicitly to
    // keep an in-flight write from landing while reset is asserted.
    assign ram_we = fire & a_we & is_ram & ~acc_err & ~reset;
    assign led_we = fire & a_we & is_led & a_be[0] & ~acc_err;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) begin
                    mem[ram_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q  <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            cyc_q   <= 32'h0;
            led_q   <= 8'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 32'd1;

            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                wcnt_q  <= LAT;
            end else if (state_q == WAIT && wcnt_q != 4'd0) begin
                wcnt_q <= wcnt_q - 4'd1;
            end

            if (led_we) begin
                led_q <= a_wdata[7:0];
            end

            if (fire) begin
                rdata_q <= acc_rdata;
                err_q   <= acc_err;
            end else if (state_q == RESP && rsp_ready) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid & err_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Drives dmem_responder with directed scenarios and randomized traffic and
//   checks every response against a word-level reference model of the
//   address map (array of RAM words, LED byte, elapsed-cycle count).
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  led_out;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .led_out   (led_out)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------------------------------------------------------- reference model
  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  ref_led = 8'h0;
  logic [31:0] tb_cyc;   // rising edges seen since reset was released

  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= 32'h0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be,
                                       input logic [31:0] cyc_val,
                                       output logic err, output logic [31:0] rdata);
    err = 1'b0;
    rdata = 32'h0;
    if (addr % 4 != 0) begin
      err = 1'b1;
    end else if (addr < DEPTH * 4) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) ref_mem[addr / 4][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        rdata = ref_mem[addr / 4];
      end
    end else if (addr == 32'h1000_0000) begin
      if (we) begin
        if (be[0]) ref_led = wdata[7:0];
      end else begin
        rdata = {24'h0, ref_led};
      end
    end else if (addr == 32'h1000_0004) begin
      if (we) err = 1'b1;
      else    rdata = cyc_val;
    end else begin
      err = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------- driver
  // One full transaction. Returns the response, the number of edges from
  // acceptance to rsp_valid (-1 on timeout), the counter value the access edge
  // should observe, how many cycles it waited for req_ready, a count of
  // protocol irregularities seen while waiting/stalled, and whether the DUT was
  // idle one edge after the response handshake.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [31:0] cyc_exp, output int acc_wait,
                        output int bad_cnt, output logic idle_after);
    int n;
    bad_cnt = 0;
    acc_wait = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_be = be;
    while (req_ready !== 1'b1 && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    @(posedge clk);
    #1;
    cyc_exp = tb_cyc + LATENCY;
    // Scramble the request fields: the DUT must use what it captured.
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_be = 4'($urandom);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) bad_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    lat = (rsp_valid === 1'b1) ? n : -1;
    rdata = rsp_rdata;
    err = rsp_err;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
        bad_cnt++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    idle_after = (req_ready === 1'b1 && rsp_valid === 1'b0 &&
                  rsp_rdata === 32'h0 && rsp_err === 1'b0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    vectors++; if (led_out !== 8'h0) begin miscompares++; $display("FAIL reset_led: got %h expected 0", led_out); end
    @(negedge clk);
    reset = 1'b0;
    ref_led = 8'h0;
  endtask

  task automatic test_ram_write_read();
    logic [31:0] rd, exp_rd, cyc;
    logic er, exp_er, idl;
    int lat, aw, bad;
    do_req(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, cyc, exp_er, exp_rd);
    vectors++; if (lat != LATENCY + 1) begin miscompares++; $display("FAIL wr_latency: got %0d expected %0d", lat, LATENCY + 1); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b expected 0", er); end
    vectors++; if (bad != 0 || idl !== 1'b1) begin miscompares++; $display("FAIL wr_protocol: got bad=%0d idle=%b expected 0/1", bad, idl); end
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h8, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (lat != LATENCY + 1) begin miscompares++; $display("FAIL rd_latency: got %0d expected %0d", lat, LATENCY + 1); end
    vectors++; if (rd !== 32'hDEAD_BEEF || rd !== exp_rd) begin miscompares++; $display("FAIL rd_deadbeef: got %h expected %h", rd, exp_rd); end
    vectors++; if (er !== exp_er) begin miscompares++; $display("FAIL rd_err: got %b expected %b", er, exp_er); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, exp_rd, cyc;
    logic er, exp_er, idl;
    int lat, aw, bad;
    do_req(1'b1, 32'h8, 32'h0000_1100, 4'b0010, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b1, 32'h8, 32'h0000_1100, 4'b0010, cyc, exp_er, exp_rd);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h8, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (rd !== 32'hDEAD_11EF || rd !== exp_rd) begin miscompares++; $display("FAIL lane1_merge: got %h expected %h", rd, exp_rd); end
    // No lanes enabled: no change, no fault.
    do_req(1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL be0_err: got %b expected 0", er); end
    do_req(1'b0, 32'h8, 32'h0, 4'hF, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h8, 32'h0, 4'hF, cyc, exp_er, exp_rd);
    vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL be0_unchanged: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, exp_rd, cyc;
    logic er, exp_er, idl;
    int lat, aw, bad;
    logic [31:0] addrs [3];
    logic        wes [3];
    addrs[0] = 32'h0000_0006; wes[0] = 1'b0;
    addrs[1] = 32'h2000_0000; wes[1] = 1'b0;
    addrs[2] = 32'h1000_0004; wes[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_req(wes[i], addrs[i], 32'h1234_5678, 4'hF, 1, rd, er, lat, cyc, aw, bad, idl);
      model_access(wes[i], addrs[i], 32'h1234_5678, 4'hF, cyc, exp_er, exp_rd);
      vectors++; if (er !== 1'b1 || er !== exp_er) begin miscompares++; $display("FAIL fault_err[%h]: got %b expected 1", addrs[i], er); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL fault_rdata[%h]: got %h expected 0", addrs[i], rd); end
    end
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h8, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL fault_ram_kept: got %h expected %h", rd, exp_rd); end
    do_req(1'b0, 32'h1000_0004, 32'h0, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h1000_0004, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (rd !== exp_rd || er !== 1'b0) begin miscompares++; $display("FAIL counter_read: got %h/%b expected %h/0", rd, er, exp_rd); end
  endtask

  task automatic test_led();
    logic [31:0] rd, exp_rd, cyc;
    logic er, exp_er, idl;
    int lat, aw, bad;
    do_req(1'b1, 32'h1000_0000, 32'h0000_01A5, 4'b0001, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b1, 32'h1000_0000, 32'h0000_01A5, 4'b0001, cyc, exp_er, exp_rd);
    vectors++; if (led_out !== 8'hA5 || led_out !== ref_led) begin miscompares++; $display("FAIL led_write: got %h expected %h", led_out, ref_led); end
    do_req(1'b0, 32'h1000_0000, 32'h0, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h1000_0000, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (rd !== 32'h0000_00A5 || rd !== exp_rd) begin miscompares++; $display("FAIL led_read: got %h expected %h", rd, exp_rd); end
    do_req(1'b1, 32'h1000_0000, 32'h0000_00FF, 4'b1110, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b1, 32'h1000_0000, 32'h0000_00FF, 4'b1110, cyc, exp_er, exp_rd);
    vectors++; if (led_out !== ref_led) begin miscompares++; $display("FAIL led_be0_off: got %h expected %h", led_out, ref_led); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, exp_rd, cyc;
    logic er, exp_er, idl;
    int lat, aw, bad;
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 5, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h8, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL stall_stable: got %0d irregular cycles expected 0", bad); end
    vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL stall_rdata: got %h expected %h", rd, exp_rd); end
    vectors++; if (idl !== 1'b1) begin miscompares++; $display("FAIL stall_release_idle: got %b expected 1", idl); end
    do_req(1'b0, 32'h6, 32'h0, 4'h0, 5, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h6, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (bad != 0 || er !== 1'b1) begin miscompares++; $display("FAIL stall_err_stable: got bad=%0d err=%b expected 0/1", bad, er); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, exp_rd, cyc;
    logic er, exp_er, idl;
    int lat, aw, bad;
    do_req(1'b1, 32'h1000_0000, 32'h0000_005A, 4'h1, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b1, 32'h1000_0000, 32'h0000_005A, 4'h1, cyc, exp_er, exp_rd);
    do_req(1'b1, 32'h4, 32'h1111_1111, 4'hF, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b1, 32'h4, 32'h1111_1111, 4'hF, cyc, exp_er, exp_rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h2222_2222; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
    vectors++; if (led_out !== 8'h0) begin miscompares++; $display("FAIL abort_led: got %h expected 0", led_out); end
    ref_led = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h4, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (rd !== 32'h1111_1111 || rd !== exp_rd) begin miscompares++; $display("FAIL abort_no_write: got %h expected %h", rd, exp_rd); end
    vectors++; if (led_out !== 8'h0) begin miscompares++; $display("FAIL abort_led_after: got %h expected 0", led_out); end
    do_req(1'b0, 32'h1000_0004, 32'h0, 4'h0, 0, rd, er, lat, cyc, aw, bad, idl);
    model_access(1'b0, 32'h1000_0004, 32'h0, 4'h0, cyc, exp_er, exp_rd);
    vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL counter_after_reset: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp_rd, cyc, a;
    logic er, exp_er, idl;
    int lat, aw, bad;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4 + 16);
      do_req(i[0], a, 32'hA5A5_0000 + 32'(i), 4'hF, 0, rd, er, lat, cyc, aw, bad, idl);
      model_access(i[0], a, 32'hA5A5_0000 + 32'(i), 4'hF, cyc, exp_er, exp_rd);
      if (i > 0) begin
        vectors++; if (aw != 0) begin miscompares++; $display("FAIL b2b_accept_gap[%0d]: got %0d extra cycles expected 0", i, aw); end
      end
      vectors++; if (lat != LATENCY + 1 || er !== exp_er) begin miscompares++; $display("FAIL b2b_rsp[%0d]: got lat=%0d err=%b expected %0d/%b", i, lat, er, LATENCY + 1, exp_er); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, cyc, addr, wdata;
    logic er, exp_er, idl, we;
    logic [3:0] be;
    int lat, aw, bad, hold;
    // Give every RAM word a known value first.
    for (int w = 0; w < DEPTH; w++) begin
      wdata = $urandom;
      do_req(1'b1, 32'(w * 4), wdata, 4'hF, 0, rd, er, lat, cyc, aw, bad, idl);
      model_access(1'b1, 32'(w * 4), wdata, 4'hF, cyc, exp_er, exp_rd);
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL init_err[%0d]: got %b expected 0", w, er); end
    end
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 5))
        0, 1: addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        2:    addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        3:    addr = 32'h1000_0000;
        4:    addr = 32'h1000_0004;
        default: begin
          case ($urandom_range(0, 2))
            0:       addr = 32'(DEPTH * 4 + $urandom_range(0, 1000) * 4);
            1:       addr = 32'h1000_0008 + 32'($urandom_range(0, 1000) * 4);
            default: addr = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
          endcase
        end
      endcase
      we = 1'($urandom);
      wdata = $urandom;
      be = 4'($urandom);
      hold = $urandom_range(0, 3);
      do_req(we, addr, wdata, be, hold, rd, er, lat, cyc, aw, bad, idl);
      model_access(we, addr, wdata, be, cyc, exp_er, exp_rd);
      vectors++; if (er !== exp_er) begin miscompares++; $display("FAIL rnd_err[%0d] addr=%h we=%b: got %b expected %b", k, addr, we, er, exp_er); end
      if (!we || exp_er) begin
        vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL rnd_rdata[%0d] addr=%h: got %h expected %h", k, addr, rd, exp_rd); end
      end
      vectors++; if (lat != LATENCY + 1 || bad != 0 || idl !== 1'b1) begin miscompares++; $display("FAIL rnd_protocol[%0d]: got lat=%0d bad=%0d idle=%b expected %0d/0/1", k, lat, bad, idl, LATENCY + 1); end
      vectors++; if (led_out !== ref_led) begin miscompares++; $display("FAIL rnd_led[%0d]: got %h expected %h", k, led_out, ref_led); end
    end
  endtask

  // ---------------------------------------------------------------- sequence/report
  initial begin
    test_reset();
    test_ram_write_read();
    test_byte_lanes();
    test_errors();
    test_led();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
